// File: rtl/microcode_sequencer.sv
// microcode_sequencer
//   Control-side partner of the microcode ROM. Fetches opcode bytes (with
//   0xCB selecting the extended page), produces the 9-bit ROM address
//   {page, index}, and steps/stalls/retires/halts on the returned control word.
//
// Ports
//   i_clk, i_rst        clock, async active-high reset
//   o_fetch_req         request next instruction byte
//   i_fetch_ack/data    fetched byte handshake
//   o_uc_addr/o_uc_valid  ROM address and "control word executing" flag
//   i_uc_next/last/mem/halt  control word fields for current o_uc_addr
//   i_mem_ack           memory access of current micro-op completes
//   i_irq               interrupt pending (wakes HALT)
//   o_instr_done        one-cycle retirement pulse
//   o_uc_error          sticky step-watchdog error
//
// state    | meaning
// S_FETCH  | requesting opcode byte
// S_FETCH_CB | prefix seen, requesting extended opcode byte
// S_EXEC   | executing control words from ROM
// S_HALT   | stopped; irq resumes unless watchdog error is set
module microcode_sequencer #(
  parameter logic [7:0] CB_PREFIX = 8'hCB,
  parameter int         MAX_STEPS = 12,
  parameter int         STEP_W    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_fetch_req,
  input  logic       i_fetch_ack,
  input  logic [7:0] i_fetch_data,
  output logic [8:0] o_uc_addr,
  output logic       o_uc_valid,
  input  logic [8:0] i_uc_next,
  input  logic       i_uc_last,
  input  logic       i_uc_mem,
  input  logic       i_mem_ack,
  input  logic       i_uc_halt,
  input  logic       i_irq,
  output logic       o_instr_done,
  output logic       o_uc_error
);

  typedef enum logic [1:0] {S_FETCH, S_FETCH_CB, S_EXEC, S_HALT} state_t;

  state_t            r_state;
  logic              r_cb_flag;
  logic [STEP_W-1:0] r_step;
  logic              r_fetch_req;
  logic [8:0]        r_uc_addr;
  logic              r_uc_valid;
  logic              r_instr_done;
  logic              r_uc_error;

  logic w_stall;
  logic w_wdog;

  // A stalled memory micro-op is not evaluated further, so it never trips the watchdog.
  assign w_stall = i_uc_mem & ~i_mem_ack;
  assign w_wdog  = (r_step == STEP_W'(MAX_STEPS - 1)) & ~i_uc_last & ~i_uc_halt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_FETCH;
      r_cb_flag    <= 1'b0;
      r_step       <= '0;
      r_fetch_req  <= 1'b0;
      r_uc_addr    <= '0;
      r_uc_valid   <= 1'b0;
      r_instr_done <= 1'b0;
      r_uc_error   <= 1'b0;
    end else begin
      r_instr_done <= 1'b0;
      case (r_state)
        S_FETCH: begin
          r_fetch_req <= 1'b1;
          if (i_fetch_ack) begin
            if (i_fetch_data == CB_PREFIX) begin
              r_cb_flag <= 1'b1;
              r_state   <= S_FETCH_CB;
            end else begin
              r_uc_addr   <= {1'b0, i_fetch_data};
              r_step      <= '0;
              r_state     <= S_EXEC;
              r_fetch_req <= 1'b0;
              r_uc_valid  <= 1'b1;
            end
          end
        end
        S_FETCH_CB: begin
          r_fetch_req <= 1'b1;
          if (i_fetch_ack) begin
            // cb_flag is 1 here, so it forms the extended page bit.
            r_uc_addr   <= {r_cb_flag, i_fetch_data};
            r_cb_flag   <= 1'b0;
            r_step      <= '0;
            r_state     <= S_EXEC;
            r_fetch_req <= 1'b0;
            r_uc_valid  <= 1'b1;
          end
        end
        S_EXEC: begin
          if (!w_stall) begin
            if (w_wdog) begin
              r_uc_error <= 1'b1;
              r_state    <= S_HALT;
              r_uc_valid <= 1'b0;
            end else if (i_uc_halt) begin
              r_instr_done <= i_uc_last;
              r_state      <= S_HALT;
              r_uc_valid   <= 1'b0;
            end else if (i_uc_last) begin
              r_instr_done <= 1'b1;
              r_state      <= S_FETCH;
              r_uc_valid   <= 1'b0;
              r_fetch_req  <= 1'b1;
            end else begin
              r_uc_addr <= i_uc_next;
              r_step    <= r_step + 1'b1;
            end
          end
        end
        S_HALT: begin
          if (i_irq && !r_uc_error) begin
            r_state     <= S_FETCH;
            r_fetch_req <= 1'b1;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign o_fetch_req  = r_fetch_req;
  assign o_uc_addr    = r_uc_addr;
  assign o_uc_valid   = r_uc_valid;
  assign o_instr_done = r_instr_done;
  assign o_uc_error   = r_uc_error;

endmodule

// File: tb/tb_microcode_sequencer.sv
module tb_microcode_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_req;
  logic       fetch_ack;
  logic [7:0] fetch_data;
  logic [8:0] uc_addr;
  logic       uc_valid;
  logic [8:0] uc_next;
  logic       uc_last;
  logic       uc_mem;
  logic       mem_ack;
  logic       uc_halt;
  logic       irq;
  logic       instr_done;
  logic       uc_error;

  int n_pass  = 0;
  int n_total = 0;

  logic [8:0] q_addr[$];
  logic       q_done[$];

  microcode_sequencer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_fetch_req  (fetch_req),
    .i_fetch_ack  (fetch_ack),
    .i_fetch_data (fetch_data),
    .o_uc_addr    (uc_addr),
    .o_uc_valid   (uc_valid),
    .i_uc_next    (uc_next),
    .i_uc_last    (uc_last),
    .i_uc_mem     (uc_mem),
    .i_mem_ack    (mem_ack),
    .i_uc_halt    (uc_halt),
    .i_irq        (irq),
    .o_instr_done (instr_done),
    .o_uc_error   (uc_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every executing cycle must match the next expected address,
  // every retirement pulse the next expected fetch_req level.
  always @(negedge clk) begin
    if (!rst) begin
      if (uc_valid === 1'b1) begin
        if (q_addr.size() == 0) chk("unexpected_uc_valid", {23'd0, uc_addr}, 32'h0);
        else chk("uc_addr", {23'd0, uc_addr}, {23'd0, q_addr.pop_front()});
      end
      if (instr_done === 1'b1) begin
        if (q_done.size() == 0) chk("unexpected_instr_done", 32'd1, 32'd0);
        else chk("done_fetch_req", {31'd0, fetch_req}, {31'd0, q_done.pop_front()});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_byte(input logic [7:0] b);
    fetch_ack  = 1'b1;
    fetch_data = b;
    tick();
    fetch_ack  = 1'b0;
    fetch_data = 8'h00;
  endtask

  task automatic cw(input logic [8:0] nxt, input logic last, input logic mem,
                    input logic ack, input logic halt);
    uc_next = nxt; uc_last = last; uc_mem = mem; mem_ack = ack; uc_halt = halt;
    tick();
    uc_next = 9'h0; uc_last = 1'b0; uc_mem = 1'b0; mem_ack = 1'b0; uc_halt = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fetch_ack = 1'b0; fetch_data = 8'h00; uc_next = 9'h0;
    uc_last = 1'b0; uc_mem = 1'b0; mem_ack = 1'b0; uc_halt = 1'b0; irq = 1'b0;
    #3;
    chk("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
    chk("rst_uc_addr", {23'd0, uc_addr}, 32'd0);
    chk("rst_uc_valid", {31'd0, uc_valid}, 32'd0);
    chk("rst_instr_done", {31'd0, instr_done}, 32'd0);
    chk("rst_uc_error", {31'd0, uc_error}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    chk("fetch_req_idle", {31'd0, fetch_req}, 32'd1);

    // plain opcode, single-word instruction
    q_addr.push_back(9'h03E);
    fetch_byte(8'h3E);
    q_done.push_back(1'b1);
    cw(9'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fetch_req_after_retire", {31'd0, fetch_req}, 32'd1);

    // CB prefix
    fetch_byte(8'hCB);
    chk("cb_no_valid", {31'd0, uc_valid}, 32'd0);
    chk("cb_fetch_req", {31'd0, fetch_req}, 32'd1);
    q_addr.push_back(9'h111);
    fetch_byte(8'h11);
    q_done.push_back(1'b1);
    cw(9'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // CB CB -> extended opcode 0xCB
    fetch_byte(8'hCB);
    q_addr.push_back(9'h1CB);
    fetch_byte(8'hCB);
    q_done.push_back(1'b1);
    cw(9'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // multi-step via uc_next
    q_addr.push_back(9'h042);
    fetch_byte(8'h42);
    q_addr.push_back(9'h1A0);
    cw(9'h1A0, 1'b0, 1'b0, 1'b0, 1'b0);
    q_addr.push_back(9'h1A0);
    cw(9'h1A0, 1'b0, 1'b0, 1'b0, 1'b0);
    q_done.push_back(1'b1);
    cw(9'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // memory stall, 3 cycles, then ack; fetch_ack ignored in EXEC
    q_addr.push_back(9'h010);
    fetch_byte(8'h10);
    for (int i = 0; i < 3; i++) begin
      q_addr.push_back(9'h010);
      fetch_ack = 1'b1; fetch_data = 8'h77;
      cw(9'h055, 1'b0, 1'b1, 1'b0, 1'b0);
      fetch_ack = 1'b0;
    end
    q_addr.push_back(9'h055);
    cw(9'h055, 1'b0, 1'b1, 1'b1, 1'b0);
    q_done.push_back(1'b1);
    cw(9'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stall_no_error", {31'd0, uc_error}, 32'd0);

    // halt + last together, then irq wake
    q_addr.push_back(9'h076);
    fetch_byte(8'h76);
    q_done.push_back(1'b0);
    cw(9'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("halt_uc_valid", {31'd0, uc_valid}, 32'd0);
    tick(); tick();
    chk("halt_no_fetch", {31'd0, fetch_req}, 32'd0);
    irq = 1'b1;
    tick();
    irq = 1'b0;
    chk("irq_wake_fetch_req", {31'd0, fetch_req}, 32'd1);

    // exactly MAX_STEPS words, last on final one: no watchdog
    q_addr.push_back(9'h021);
    fetch_byte(8'h21);
    for (int i = 0; i < 11; i++) begin
      q_addr.push_back(9'h100 + 9'(i));
      cw(9'h100 + 9'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    q_done.push_back(1'b1);
    cw(9'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wdog_boundary_no_error", {31'd0, uc_error}, 32'd0);

    // never-ending instruction trips watchdog
    q_addr.push_back(9'h020);
    fetch_byte(8'h20);
    for (int i = 0; i < 11; i++) begin
      q_addr.push_back(9'h080 + 9'(i));
      cw(9'h080 + 9'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("wdog_not_yet", {31'd0, uc_error}, 32'd0);
    cw(9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wdog_error", {31'd0, uc_error}, 32'd1);
    chk("wdog_uc_valid", {31'd0, uc_valid}, 32'd0);
    chk("wdog_addr_held", {23'd0, uc_addr}, 32'h08A);
    irq = 1'b1;
    tick(); tick();
    irq = 1'b0;
    chk("wdog_irq_ignored", {31'd0, fetch_req}, 32'd0);
    chk("wdog_sticky", {31'd0, uc_error}, 32'd1);

    // reset clears sticky error immediately
    rst = 1'b1;
    #1;
    chk("rst_clears_error", {31'd0, uc_error}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // reset mid-EXEC
    fetch_byte(8'h30);
    chk("exec_valid_pre_rst", {31'd0, uc_valid}, 32'd1);
    chk("exec_addr_pre_rst", {23'd0, uc_addr}, 32'h030);
    rst = 1'b1;
    #1;
    chk("midrst_uc_valid", {31'd0, uc_valid}, 32'd0);
    chk("midrst_uc_addr", {23'd0, uc_addr}, 32'd0);
    chk("midrst_fetch_req", {31'd0, fetch_req}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(); tick();

    chk("addr_queue_drained", q_addr.size(), 32'd0);
    chk("done_queue_drained", q_done.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
